// File: rtl/madd_seq_approx.sv
// Sequential shift-add a*b+c with a per-transaction truncated-partial-product (approximate) mode.
// Optional error monitor: define MADD_ERR_MON_EN to add the err_flag port and exact reference.
module madd_seq_approx #(
    parameter int unsigned W          = 2,
    parameter int unsigned TRUNC      = 1,
    parameter int unsigned ERR_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   result
`ifdef MADD_ERR_MON_EN
    ,
    output logic             err_flag
`endif
);

    localparam int unsigned AW = 2 * W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [AW-1:0] KEEP_MASK = {AW{1'b1}} << TRUNC;
    localparam logic [CW-1:0] CNT_LAST  = CW'(W - 1);

    // The threshold must also fit the 2W-bit error magnitude.
    if (W < 2 || TRUNC > W || (64'(ERR_THRESH) >> (2 * W)) != 64'd0) begin : g_bad_params
        $error("madd_seq_approx: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            approx_q, approx_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   result_q, result_d;
    logic [AW-1:0]   pp, pp_eff;
    logic            accept;

    assign accept = (state_q == IDLE) && in_valid && in_ready_q;

    always_comb begin
        pp     = AW'(a_q) << cnt_q;
        pp_eff = approx_q ? (pp & KEEP_MASK) : pp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MUL;
            MUL:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        approx_d = approx_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = a;
                    b_d      = b;
                    approx_d = approx_en;
                    acc_d    = AW'(c);
                    cnt_d    = '0;
                end
            end
            MUL: begin
                if (b_q[cnt_q]) acc_d = acc_q + pp_eff;
                cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
        if (state_q == MUL && state_d == DONE) result_d = acc_d;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            approx_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            approx_q    <= approx_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef MADD_ERR_MON_EN
    logic [W-1:0]  c_q, c_d;
    logic          err_q, err_d;
    logic [AW-1:0] exact_ref, abs_err;

    // Error is judged against the final accumulator value on the MUL->DONE edge.
    always_comb begin
        exact_ref = AW'(a_q) * AW'(b_q) + AW'(c_q);
        abs_err   = (exact_ref >= acc_d) ? (exact_ref - acc_d) : (acc_d - exact_ref);
        c_d       = c_q;
        err_d     = err_q;
        if (accept) c_d = c;
        if (state_q == MUL && state_d == DONE) begin
            err_d = (abs_err > AW'(ERR_THRESH));
        end else if (state_d != DONE) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q   <= '0;
            err_q <= 1'b0;
        end else begin
            c_q   <= c_d;
            err_q <= err_d;
        end
    end

    assign err_flag = err_q;
`endif

endmodule
